multicycle_control_unit: RTL and testbench

Moore-style sequencing FSM for the RV32I multicycle datapath. It drives every enable and mux select of the shared datapath: PC register, address mux, instruction/data memory, IR/OldPC registers, register file, SrcA/SrcB muxes, ALU, result mux and ImmGen. Each instruction walks through 3–5 states, sharing one ALU and one memory port. The block also flags unsupported encodings and counts retired instructions.

---
 rtl/multicycle_control_unit.sv | 237 +++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
//   Moore-style sequencing FSM for the RV32I multicycle datapath. Drives the
//   enables and mux selects of the shared datapath (PC, address mux, memory,
//   IR/OldPC, register file, SrcA/SrcB, ALU, result mux, ImmGen), flags
//   unsupported encodings and counts retired instructions.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-low reset
//   opcode       in   IR[6:0]
//   funct3       in   IR[14:12]
//   funct7_5     in   IR[30]
//   zero         in   ALU zero flag (same cycle)
//   pc_write     out  PC register enable
//   adr_src      out  address mux: 0 = PC, 1 = result
//   mem_write    out  memory write enable
//   ir_write     out  IR / OldPC enable
//   reg_write    out  register-file write enable
//   alu_src_a    out  00 = PC, 01 = OldPC, 10 = rs1
//   alu_src_b    out  00 = rs2, 01 = imm, 10 = constant 4
//   alu_control  out  ALU operation code
//   result_src   out  00 = ALUOut, 01 = data register, 10 = ALU result
//   imm_sel      out  000 I, 001 S, 010 B, 011 J
//   illegal      out  sticky unsupported-instruction flag
//   state        out  current FSM state (debug)
//   instr_count  out  retired-instruction count, wraps modulo 2^32

module multicycle_control_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        funct7_5,
    input  logic        zero,
    output logic        pc_write,
    output logic        adr_src,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_write,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [3:0]  alu_control,
    output logic [1:0]  result_src,
    output logic [2:0]  imm_sel,
    output logic        illegal,
    output logic [3:0]  state,
    output logic [31:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADR   = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JAL       = 4'd10,
        S_JALR_ADR  = 4'd11,
        S_JALR_JUMP = 4'd12,
        S_ILLEGAL   = 4'd13
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    state_t      r_state;
    logic        r_illegal;
    logic [31:0] r_instr_count;

    // Only R-type turns funct3=000 with IR[30] set into SUB; for I-type that
    // bit belongs to the immediate.
    function automatic logic [3:0] alu_decode(input logic [2:0] f3,
                                              input logic       f7_5,
                                              input logic       is_r);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (is_r && f7_5) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = f7_5 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= S_FETCH;
            r_illegal     <= 1'b0;
            r_instr_count <= '0;
        end else begin
            case (r_state)
                S_FETCH:     r_state <= S_DECODE;
                S_DECODE: begin
                    if (opcode == OP_R)
                        r_state <= S_EXEC_R;
                    else if (opcode == OP_I)
                        r_state <= S_EXEC_I;
                    else if ((opcode == OP_LOAD || opcode == OP_STORE) && funct3 == 3'b010)
                        r_state <= S_MEM_ADR;
                    else if (opcode == OP_BRANCH && funct3[2:1] == 2'b00)
                        r_state <= S_BRANCH;
                    else if (opcode == OP_JAL)
                        r_state <= S_JAL;
                    else if (opcode == OP_JALR && funct3 == 3'b000)
                        r_state <= S_JALR_ADR;
                    else begin
                        r_state   <= S_ILLEGAL;
                        r_illegal <= 1'b1;
                    end
                end
                S_MEM_ADR:   r_state <= (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
                S_MEM_READ:  r_state <= S_MEM_WB;
                S_EXEC_R,
                S_EXEC_I,
                S_JAL,
                S_JALR_JUMP: r_state <= S_ALU_WB;
                S_JALR_ADR:  r_state <= S_JALR_JUMP;
                S_MEM_WB,
                S_MEM_WRITE,
                S_ALU_WB,
                S_BRANCH: begin
                    r_state       <= S_FETCH;
                    r_instr_count <= r_instr_count + 32'd1;
                end
                S_ILLEGAL:   r_state <= S_ILLEGAL;
                default: begin
                    r_state   <= S_ILLEGAL;
                    r_illegal <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        pc_write    = 1'b0;
        adr_src     = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_control = ALU_ADD;
        result_src  = 2'b00;
        case (r_state)
            S_FETCH: begin
                ir_write   = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                pc_write   = 1'b1;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            S_MEM_ADR, S_JALR_ADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEM_READ:  adr_src = 1'b1;
            S_MEM_WB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            S_MEM_WRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a   = 2'b10;
                alu_control = alu_decode(funct3, funct7_5, 1'b1);
            end
            S_EXEC_I: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = alu_decode(funct3, funct7_5, 1'b0);
            end
            S_ALU_WB:    reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a   = 2'b10;
                alu_control = ALU_SUB;
                pc_write    = funct3[0] ? ~zero : zero;
            end
            S_JAL, S_JALR_JUMP: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
            end
            default: ;
        endcase
        // Reset is synchronous, so gate the enables directly to keep the
        // datapath quiet for every cycle reset is held low.
        if (!reset) begin
            pc_write  = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
        end
    end

    always_comb begin
        case (opcode)
            OP_STORE:  imm_sel = 3'b001;
            OP_BRANCH: imm_sel = 3'b010;
            OP_JAL:    imm_sel = 3'b011;
            default:   imm_sel = 3'b000;
        endcase
    end

    assign illegal     = r_illegal;
    assign state       = r_state;
    assign instr_count = r_instr_count;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit
//   Directed-vector bench for multicycle_control_unit. Each instruction is
//   driven with its expected state walk, ALU op and immediate format.

module tb_multicycle_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic        zero;
    logic        pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
    logic [1:0]  alu_src_a, alu_src_b, result_src;
    logic [3:0]  alu_control, state;
    logic [2:0]  imm_sel;
    logic [31:0] instr_count;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [31:0] exp_cnt  = '0;

    multicycle_control_unit dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
        .funct7_5(funct7_5), .zero(zero), .pc_write(pc_write),
        .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_control(alu_control), .result_src(result_src), .imm_sel(imm_sel),
        .illegal(illegal), .state(state), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // {pc_write, adr_src, mem_write, ir_write, reg_write, A, B, alu, result}
    logic [14:0] ctrl;
    assign ctrl = {pc_write, adr_src, mem_write, ir_write, reg_write,
                   alu_src_a, alu_src_b, alu_control, result_src};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Hand-written control table for each state.
    function automatic logic [14:0] exp_ctrl(input logic [3:0] s, input logic [3:0] alu,
                                             input logic bne, input logic z);
        logic [14:0] e;
        case (s)
            4'd0:    e = {5'b10010, 2'b00, 2'b10, 4'd0, 2'b10};
            4'd1:    e = {5'b00000, 2'b01, 2'b01, 4'd0, 2'b00};
            4'd2:    e = {5'b00000, 2'b10, 2'b01, 4'd0, 2'b00};
            4'd3:    e = {5'b01000, 2'b00, 2'b00, 4'd0, 2'b00};
            4'd4:    e = {5'b00001, 2'b00, 2'b00, 4'd0, 2'b01};
            4'd5:    e = {5'b01100, 2'b00, 2'b00, 4'd0, 2'b00};
            4'd6:    e = {5'b00000, 2'b10, 2'b00, alu,  2'b00};
            4'd7:    e = {5'b00000, 2'b10, 2'b01, alu,  2'b00};
            4'd8:    e = {5'b00001, 2'b00, 2'b00, 4'd0, 2'b00};
            4'd9:    e = {(bne ? ~z : z), 4'b0000, 2'b10, 2'b00, 4'd1, 2'b00};
            4'd10:   e = {5'b10000, 2'b01, 2'b10, 4'd0, 2'b00};
            4'd11:   e = {5'b00000, 2'b10, 2'b01, 4'd0, 2'b00};
            4'd12:   e = {5'b10000, 2'b01, 2'b10, 4'd0, 2'b00};
            default: e = '0;
        endcase
        return e;
    endfunction

    task automatic set_ir(input logic [31:0] ir);
        opcode   = ir[6:0];
        funct3   = ir[14:12];
        funct7_5 = ir[30];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // path: first state in the top nibble, plen states used.
    task automatic run_instr(input string name, input logic [31:0] ir, input logic z,
                             input logic [19:0] path, input int unsigned plen,
                             input logic [3:0] alu, input logic [2:0] imm);
        logic [3:0] s;
        set_ir(ir);
        zero = z;
        for (int unsigned k = 0; k < plen; k++) begin
            s = path[19 - 4*k -: 4];
            #1;
            check($sformatf("%s state[%0d]", name, k), 32'(state), 32'(s));
            check($sformatf("%s ctrl[%0d]", name, k), 32'(ctrl), 32'(exp_ctrl(s, alu, ir[12], z)));
            if (k == 1)
                check($sformatf("%s imm_sel", name), 32'(imm_sel), 32'(imm));
            tick();
        end
        exp_cnt = exp_cnt + 32'd1;
        check($sformatf("%s back_to_fetch", name), 32'(state), 32'd0);
        check($sformatf("%s instr_count", name), instr_count, exp_cnt);
        check($sformatf("%s illegal", name), 32'(illegal), 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        zero  = 1'b0;
        set_ir(32'h0000_0013);

        repeat (3) begin
            tick();
            check("rst state", 32'(state), 32'd0);
            check("rst enables", 32'({pc_write, mem_write, ir_write, reg_write}), 32'd0);
            check("rst count", instr_count, 32'd0);
            check("rst illegal", 32'(illegal), 32'd0);
        end
        reset = 1'b1;
        #1;
        check("rel ir_write", 32'(ir_write), 32'd1);
        check("rel pc_write", 32'(pc_write), 32'd1);
        check("rel state", 32'(state), 32'd0);

        //         name     instr          z     path       len alu    imm
        run_instr("add",   32'h002081B3, 1'b0, 20'h01680, 4, 4'd0, 3'd0);
        run_instr("sub",   32'h402081B3, 1'b0, 20'h01680, 4, 4'd1, 3'd0);
        run_instr("and",   32'h0020F1B3, 1'b0, 20'h01680, 4, 4'd2, 3'd0);
        run_instr("sltu",  32'h0020B1B3, 1'b0, 20'h01680, 4, 4'd9, 3'd0);
        run_instr("srl",   32'h0020D1B3, 1'b0, 20'h01680, 4, 4'd6, 3'd0);
        run_instr("sra",   32'h4020D1B3, 1'b0, 20'h01680, 4, 4'd7, 3'd0);
        run_instr("addi",  32'h40000093, 1'b0, 20'h01780, 4, 4'd0, 3'd0);
        run_instr("srai",  32'h4030D093, 1'b0, 20'h01780, 4, 4'd7, 3'd0);
        run_instr("xori",  32'h0000C093, 1'b0, 20'h01780, 4, 4'd4, 3'd0);
        run_instr("lw",    32'h0000A283, 1'b0, 20'h01234, 5, 4'd0, 3'd0);
        run_instr("sw",    32'h0050A023, 1'b0, 20'h01250, 4, 4'd0, 3'd1);
        run_instr("beq_t", 32'h00208063, 1'b1, 20'h01900, 3, 4'd0, 3'd2);
        run_instr("beq_n", 32'h00208063, 1'b0, 20'h01900, 3, 4'd0, 3'd2);
        run_instr("bne_t", 32'h00209063, 1'b0, 20'h01900, 3, 4'd0, 3'd2);
        run_instr("bne_n", 32'h00209063, 1'b1, 20'h01900, 3, 4'd0, 3'd2);
        run_instr("jal",   32'h000000EF, 1'b0, 20'h01A80, 4, 4'd0, 3'd3);
        run_instr("jalr",  32'h000100E7, 1'b0, 20'h01BC8, 5, 4'd0, 3'd0);

        // Reset in the middle of a store must suppress the pending write.
        set_ir(32'h0050A023);
        tick(); tick(); tick();
        check("mid sw state", 32'(state), 32'd5);
        check("mid sw mem_write", 32'(mem_write), 32'd1);
        reset = 1'b0;
        #1;
        check("mid rst mem_write", 32'(mem_write), 32'd0);
        tick();
        exp_cnt = '0;
        check("mid rst state", 32'(state), 32'd0);
        check("mid rst count", instr_count, exp_cnt);
        check("mid rst ir_write", 32'(ir_write), 32'd0);
        reset = 1'b1;
        #1;

        // Unsupported opcode: parks in ILLEGAL until reset.
        set_ir(32'h0000007F);
        tick(); tick();
        for (int unsigned i = 0; i < 20; i++) begin
            check("ill state", 32'(state), 32'd13);
            check("ill flag", 32'(illegal), 32'd1);
            check("ill enables", 32'({pc_write, mem_write, ir_write, reg_write}), 32'd0);
            tick();
        end
        check("ill count", instr_count, exp_cnt);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        check("ill rst state", 32'(state), 32'd0);
        check("ill rst flag", 32'(illegal), 32'd0);

        // Unsupported funct3 on an otherwise legal opcode (blt, lh).
        set_ir(32'h0020C063);
        tick(); tick();
        check("blt state", 32'(state), 32'd13);
        check("blt flag", 32'(illegal), 32'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        set_ir(32'h00009283);
        tick(); tick();
        check("lh state", 32'(state), 32'd13);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        check("lh rst flag", 32'(illegal), 32'd0);

        run_instr("add2",  32'h002081B3, 1'b0, 20'h01680, 4, 4'd0, 3'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
